multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle MIPS controller FSM; drives the ALU operation code and all datapath write enables and mux selects; consumes the ALU zero flag for branches.
- Sits between the instruction register (opcode/funct) and the shared datapath: PC, IR, GRF, DM, ALU, EXT.
- Replaces per-instruction single-cycle decoding with a sequenced 3–5 cycle execution per instruction.

Parameters:
- FETCH_PC_INC, 4, constant selected by alu_src_b=2'b01 during FETCH; documents the PC increment only, no logic change.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (C==0)
- alu_op  out  3  000 add, 001 sub, 010 or
- alu_src_a  out  2  0 PC, 1 rs, 2 constant zero
- alu_src_b  out  2  0 rt, 1 FETCH_PC_INC, 2 ext(imm), 3 ext(imm)<<2
- ext_op  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16
- pc_wr  out  1  PC write enable
- pc_src  out  2  0 ALU result, 1 ALUOut reg, 2 {PC[31:28],idx,2'b00}, 3 rs
- ir_wr  out  1  IR write enable
- reg_wr  out  1  GRF write enable
- reg_dst  out  2  0 rt, 1 rd, 2 $31
- mem_to_reg  out  2  0 ALUOut, 1 DM read data, 2 PC
- mem_wr  out  1  DM write enable
- state  out  3  current FSM state, for debug
- halted  out  1  high in HALT state; tied 0 when the optional feature is off

Behaviour:
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, BR=5, JMP=6, HALT=7.
- All outputs are a Moore function of state plus a 4-bit instruction class register `cls`.
- `cls` is captured at the end of DECODE from opcode/funct.
- Classes (opcode/funct):
  - ADDU: 000000/100001
  - SUBU: 000000/100011
  - JR: 000000/001000
  - NOP: all zero
  - ORI: 001101
  - LW: 100011
  - SW: 101011
  - BEQ: 000100
  - LUI: 001111
  - J: 000010
  - JAL: 000011
  - anything else: ILL
- FETCH:
  - Outputs: ir_wr=1, pc_wr=1, pc_src=0, alu_src_a=0, alu_src_b=1, alu_op=add.
  - Next: DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, ext_op=1, alu_op=add (branch target into ALUOut); no write enables.
  - Next by class:
    - ADDU, SUBU, ORI, LUI, LW, SW → EXE
    - BEQ → BR
    - J, JAL, JR → JMP
    - NOP → FETCH
    - ILL → FETCH (HALT when the optional feature is on)
- EXE (ALU inputs per class):
  - ADDU: rs,rt, add
  - SUBU: rs,rt, sub
  - ORI: rs, zero-ext imm, or
  - LUI: zero, imm<<16, or
  - LW/SW: rs, sign-ext imm, add
  - Next: LW/SW → MEM; others → WB.
- MEM:
  - SW: mem_wr=1, next FETCH.
  - LW: no writes, next WB.
- WB:
  - reg_wr=1.
  - reg_dst: 1 for ADDU/SUBU, 0 otherwise.
  - mem_to_reg: 1 for LW, 0 otherwise.
  - Next: FETCH.
- BR:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_src=1, pc_wr=zero.
  - Next: FETCH.
- JMP:
  - pc_wr=1; pc_src=3 for JR, 2 otherwise.
  - JAL additionally: reg_wr=1, reg_dst=2, mem_to_reg=2.
  - PC already holds PC+4, so $31 = PC+4.
  - Next: FETCH.
- Cycle counts per instruction:
  - BEQ, J, JAL, JR: 3
  - NOP: 2
  - ADDU, SUBU, ORI, LUI, SW: 4
  - LW: 5
- Reset:
  - On a rising clk edge with reset=0: state←FETCH, cls←NOP.
  - While reset=0, pc_wr, ir_wr, reg_wr and mem_wr are forced 0 combinationally.
  - Mux selects take FETCH values; halted=0.
  - Reset asserted mid-instruction aborts it, with no partial write in that cycle.
- Undriven selects are 0 in every state; alu_op defaults to add.
- Unused state encodings go to FETCH on the next edge.

Optional Feature:
- Macro: MCTRL_ILLEGAL_TRAP_EN.
- Defined:
  - ILL in DECODE → HALT.
  - HALT holds: all enables 0, halted=1; left only by reset.
- Undefined:
  - ILL executes as NOP (DECODE → FETCH).
  - HALT is unreachable; halted is constant 0.

Test Plan:
- Reset low 2 cycles, release, feed addu (000000/100001) → state 0,1,2,4,0; reg_wr=1 only in WB with reg_dst=1; no enables during reset.
- lw (100011) → states 0,1,2,3,4; ext_op=1 in EXE; mem_to_reg=1 and reg_wr=1 in WB; 5 cycles total.
- beq with zero=1, then zero=0 → pc_wr=1 / pc_wr=0 in BR; pc_src=1, alu_op=001; back to FETCH after 3 cycles.
- jal (000011) → JMP with pc_wr=1, pc_src=2, reg_wr=1, reg_dst=2, mem_to_reg=2; jr → pc_src=3, reg_wr=0.
- lui (001111) in EXE → alu_src_a=2, ext_op=2, alu_op=010; reset pulled low in EXE → next state FETCH, no reg_wr.
- opcode 111111 → with MCTRL_ILLEGAL_TRAP_EN: state 7, halted=1, stays 7 for 10 cycles until reset; without it: returns to FETCH after 2 cycles, halted=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The controller (master) consumes instruction fields and the ALU zero flag
// and drives every datapath enable and mux select.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] ext_op;
  logic       pc_wr;
  logic [1:0] pc_src;
  logic       ir_wr;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       mem_wr;
  logic [2:0] state;
  logic       halted;

  modport master (
    input  opcode, funct, zero,
    output alu_op, alu_src_a, alu_src_b, ext_op, pc_wr, pc_src, ir_wr,
           reg_wr, reg_dst, mem_to_reg, mem_wr, state, halted
  );

  modport slave (
    output opcode, funct, zero,
    input  alu_op, alu_src_a, alu_src_b, ext_op, pc_wr, pc_src, ir_wr,
           reg_wr, reg_dst, mem_to_reg, mem_wr, state, halted
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS controller: sequences FETCH/DECODE/EXE/MEM/WB/BR/JMP and
// drives the shared datapath as a Moore function of (state, instruction class).
// Optional macro MCTRL_ILLEGAL_TRAP_EN: an illegal instruction parks the FSM
// in HALT (halted=1) until reset; without it an illegal instruction is a NOP.
module multicycle_ctrl #(
  parameter int unsigned FETCH_PC_INC = 4  // constant behind alu_src_b=2'b01
) (
  input  logic             clk,
  input  logic             reset,  // synchronous, active low
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXE = 3'd2, S_MEM  = 3'd3,
    S_WB    = 3'd4, S_BR     = 3'd5, S_JMP = 3'd6, S_HALT = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW,
    C_BEQ, C_LUI, C_J, C_JAL, C_ILL
  } cls_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  // The ALU constant input is wired to 4 in the datapath; refuse other values.
  if (FETCH_PC_INC != 4) begin : g_bad_pc_inc
    $error("multicycle_ctrl: FETCH_PC_INC must be 4");
  end

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  cls_e   cls_dec;
  state_e out_state;

  // Classify the instruction currently held in IR.
  always_comb begin
    cls_dec = C_ILL;
    case (bus.opcode)
      6'b000000: begin
        case (bus.funct)
          6'b100001: cls_dec = C_ADDU;
          6'b100011: cls_dec = C_SUBU;
          6'b001000: cls_dec = C_JR;
          6'b000000: cls_dec = C_NOP;
          default:   cls_dec = C_ILL;
        endcase
      end
      6'b001101: cls_dec = C_ORI;
      6'b100011: cls_dec = C_LW;
      6'b101011: cls_dec = C_SW;
      6'b000100: cls_dec = C_BEQ;
      6'b001111: cls_dec = C_LUI;
      6'b000010: cls_dec = C_J;
      6'b000011: cls_dec = C_JAL;
      default:   cls_dec = C_ILL;
    endcase
  end

  // State and class registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NOP;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Next-state logic; the class is latched on leaving DECODE.
  // NOTE: every comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_d = S_FETCH;
    cls_d   = cls_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        cls_d = cls_dec;
        case (cls_dec)
          C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW: state_d = S_EXE;
          C_BEQ:              state_d = S_BR;
          C_J, C_JAL, C_JR:   state_d = S_JMP;
`ifdef MCTRL_ILLEGAL_TRAP_EN
          C_ILL:              state_d = S_HALT;
`endif
          default:            state_d = S_FETCH;
        endcase
      end
      S_EXE:   state_d = (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
      S_MEM:   state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
`ifdef MCTRL_ILLEGAL_TRAP_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Moore outputs; reset shows FETCH selects with every write enable held off.
  always_comb begin
    bus.alu_op     = ALU_ADD;
    bus.alu_src_a  = 2'd0;
    bus.alu_src_b  = 2'd0;
    bus.ext_op     = 2'd0;
    bus.pc_wr      = 1'b0;
    bus.pc_src     = 2'd0;
    bus.ir_wr      = 1'b0;
    bus.reg_wr     = 1'b0;
    bus.reg_dst    = 2'd0;
    bus.mem_to_reg = 2'd0;
    bus.mem_wr     = 1'b0;
    bus.halted     = 1'b0;
    out_state      = reset ? state_q : S_FETCH;
    case (out_state)
      S_FETCH: begin
        bus.ir_wr     = 1'b1;
        bus.pc_wr     = 1'b1;
        bus.alu_src_b = 2'd1;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'd3;
        bus.ext_op    = 2'd1;
      end
      S_EXE: begin
        case (cls_q)
          C_ADDU: bus.alu_src_a = 2'd1;
          C_SUBU: begin
            bus.alu_src_a = 2'd1;
            bus.alu_op    = ALU_SUB;
          end
          C_ORI: begin
            bus.alu_src_a = 2'd1;
            bus.alu_src_b = 2'd2;
            bus.alu_op    = ALU_OR;
          end
          C_LUI: begin
            bus.alu_src_a = 2'd2;
            bus.alu_src_b = 2'd2;
            bus.ext_op    = 2'd2;
            bus.alu_op    = ALU_OR;
          end
          C_LW, C_SW: begin
            bus.alu_src_a = 2'd1;
            bus.alu_src_b = 2'd2;
            bus.ext_op    = 2'd1;
          end
          default: ;
        endcase
      end
      S_MEM: bus.mem_wr = (cls_q == C_SW);
      S_WB: begin
        bus.reg_wr     = 1'b1;
        bus.reg_dst    = (cls_q == C_ADDU || cls_q == C_SUBU) ? 2'd1 : 2'd0;
        bus.mem_to_reg = (cls_q == C_LW) ? 2'd1 : 2'd0;
      end
      S_BR: begin
        bus.alu_src_a = 2'd1;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = 2'd1;
        bus.pc_wr     = bus.zero;
      end
      S_JMP: begin
        bus.pc_wr  = 1'b1;
        bus.pc_src = (cls_q == C_JR) ? 2'd3 : 2'd2;
        if (cls_q == C_JAL) begin
          bus.reg_wr     = 1'b1;
          bus.reg_dst    = 2'd2;
          bus.mem_to_reg = 2'd2;
        end
      end
`ifdef MCTRL_ILLEGAL_TRAP_EN
      S_HALT: bus.halted = 1'b1;
`endif
      default: ;
    endcase
    if (!reset) begin
      bus.pc_wr  = 1'b0;
      bus.ir_wr  = 1'b0;
      bus.reg_wr = 1'b0;
      bus.mem_wr = 1'b0;
    end
  end

  assign bus.state = state_q;

endmodule
